// File: rtl/alu16_datapath.sv
// ALU16 datapath: A/Q/Q_1/M/CNT register file plus output register, driven by the
// 19-bit micro-op word from Control_Unit; status lines are decoded from registers only.
module alu16_datapath #(
    parameter int W        = 16,
    parameter int CNT_LAST = 15
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic [18:0]  c,
    input  logic [W-1:0] inbus,
    output logic [W-1:0] outbus,
    output logic         q0,
    output logic         q_1,
    output logic         a_16,
    output logic         cmp_cnt_m4,
    output logic [3:0]   cnt,
    output logic         ovf,
    output logic         err
);

    typedef enum logic [3:0] {
        A_HOLD, A_CLR, A_LOAD, A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_RESTORE, A_SHR, A_SHL
    } a_op_e;

    a_op_e        a_op;
    logic [W:0]   a_r, a_n, m_ext, m_zx, sum, diff;
    logic [W-1:0] q_r, q_n, m_r, out_r;
    logic         q1_r, q1_n;
    logic [3:0]   cnt_r;
    logic         ovf_r, err_r, conflict;

    assign m_ext    = {m_r[W-1], m_r};
    assign m_zx     = {1'b0, m_r};
    assign sum      = a_r + m_ext;
    assign diff     = a_r - m_ext;
    assign conflict = $countones({c[16], c[10:3], c[0]}) > 1;

    // One winner among the A-writing bits; shifts also move Q/Q_1 only when they win.
    always_comb begin
        a_op = A_HOLD;
        if      (c[0])  a_op = A_CLR;
        else if (c[3])  a_op = A_LOAD;
        else if (c[4])  a_op = A_ADD;
        else if (c[5])  a_op = A_SUB;
        else if (c[6])  a_op = A_AND;
        else if (c[7])  a_op = A_OR;
        else if (c[8])  a_op = A_XOR;
        else if (c[16]) a_op = A_RESTORE;
        else if (c[9])  a_op = A_SHR;
        else if (c[10]) a_op = A_SHL;
    end

    always_comb begin
        a_n  = a_r;
        q_n  = q_r;
        q1_n = q1_r;
        case (a_op)
            A_CLR: begin
                a_n  = '0;
                q1_n = 1'b0;
            end
            A_LOAD:    a_n = {inbus[W-1], inbus};
            A_ADD:     a_n = sum;
            A_SUB:     a_n = diff;
            A_AND:     a_n = a_r & m_zx;
            A_OR:      a_n = a_r | m_zx;
            A_XOR:     a_n = a_r ^ m_zx;
            A_RESTORE: if (a_r[W]) a_n = sum;
            A_SHR: begin
                a_n  = {a_r[W], a_r[W:1]};
                q_n  = {a_r[0], q_r[W-1:1]};
                q1_n = q_r[0];
            end
            A_SHL: begin
                a_n = {a_r[W-1:0], q_r[W-1]};
                q_n = {q_r[W-2:0], 1'b0};
            end
            default: a_n = a_r;
        endcase
        if (c[1])       q_n    = inbus;
        else if (c[11]) q_n[0] = 1'b1;
        else if (c[18]) q_n[0] = ~a_r[W];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            a_r   <= '0;
            q_r   <= '0;
            q1_r  <= 1'b0;
            m_r   <= '0;
            cnt_r <= '0;
            out_r <= '0;
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            a_r  <= a_n;
            q_r  <= q_n;
            q1_r <= q1_n;
            if (c[2]) m_r <= inbus;
            if (c[0] || c[17]) cnt_r <= '0;
            else if (c[12])    cnt_r <= cnt_r + 4'd1;
            if      (c[13]) out_r <= a_r[W-1:0];
            else if (c[14]) out_r <= q_r;
            else if (c[15]) out_r <= m_r;
            if (a_op == A_CLR)
                ovf_r <= 1'b0;
            else if ((a_op == A_ADD || a_op == A_SUB) && (a_n[W] != a_n[W-1]))
                ovf_r <= 1'b1;
            if (c[0])          err_r <= 1'b0;
            else if (conflict) err_r <= 1'b1;
        end
    end

    assign outbus     = out_r;
    assign q0         = q_r[0];
    assign q_1        = q1_r;
    assign a_16       = a_r[W];
    assign cnt        = cnt_r;
    assign cmp_cnt_m4 = (cnt_r == 4'(CNT_LAST));
    assign ovf        = ovf_r;
    assign err        = err_r;

endmodule

// File: tb/tb_alu16_datapath.sv
// Bench for alu16_datapath: directed micro-programs (Booth, division, overflow, conflict,
// counter, async reset) plus random control words against an arithmetic reference model.
module tb_alu16_datapath;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [18:0] c = '0;
    logic [15:0] inbus = '0;
    logic [15:0] outbus;
    logic        q0, q_1, a_16, cmp_cnt_m4, ovf, err;
    logic [3:0]  cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: A kept as a signed integer value, Q/M as unsigned integers.
    int mA, mQ, mQ1, mM, mCnt, mOut, mOvf, mErr;

    alu16_datapath #(.W(16), .CNT_LAST(15)) dut (
        .clk(clk), .rst_b(rst_b), .c(c), .inbus(inbus), .outbus(outbus),
        .q0(q0), .q_1(q_1), .a_16(a_16), .cmp_cnt_m4(cmp_cnt_m4),
        .cnt(cnt), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int wrap17(input longint v);
        longint t;
        t = v & 64'h1FFFF;
        return (t >= 65536) ? int'(t - 131072) : int'(t);
    endfunction

    function automatic int sext16(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    task automatic model_reset();
        mA = 0; mQ = 0; mQ1 = 0; mM = 0; mCnt = 0; mOut = 0; mOvf = 0; mErr = 0;
    endtask

    task automatic model_step(input logic [18:0] cv, input int iv);
        int nA, nQ, nQ1, writers;
        longint p;
        nA = mA; nQ = mQ; nQ1 = mQ1;
        writers = 32'(cv[0]) + 32'(cv[3]) + 32'(cv[4]) + 32'(cv[5]) + 32'(cv[6]) +
                  32'(cv[7]) + 32'(cv[8]) + 32'(cv[9]) + 32'(cv[10]) + 32'(cv[16]);
        if (cv[0]) begin
            nA = 0; nQ1 = 0; mOvf = 0; mErr = 0;
        end else begin
            if (cv[3]) nA = sext16(iv);
            else if (cv[4] || cv[5]) begin
                nA = cv[4] ? wrap17(longint'(mA) + sext16(mM)) : wrap17(longint'(mA) - sext16(mM));
                if (nA > 32767 || nA < -32768) mOvf = 1;
            end
            else if (cv[6]) nA = wrap17(longint'((mA & 32'h1FFFF) & mM));
            else if (cv[7]) nA = wrap17(longint'((mA & 32'h1FFFF) | mM));
            else if (cv[8]) nA = wrap17(longint'((mA & 32'h1FFFF) ^ mM));
            else if (cv[16]) begin
                if (mA < 0) nA = wrap17(longint'(mA) + sext16(mM));
            end
            else if (cv[9]) begin
                p   = (longint'(mA) * 131072 + longint'(mQ) * 2 + longint'(mQ1)) >>> 1;
                nQ1 = int'(p & 1);
                nQ  = int'((p >>> 1) & 64'hFFFF);
                nA  = int'(p >>> 17);
            end
            else if (cv[10]) begin
                p  = (longint'(mA) * 65536 + longint'(mQ)) * 2;
                nQ = int'(p & 64'hFFFF);
                nA = wrap17(p >>> 16);
            end
            if (writers > 1) mErr = 1;
        end
        if (cv[1])       nQ = iv;
        else if (cv[11]) nQ = nQ | 1;
        else if (cv[18]) nQ = (nQ & 32'hFFFE) | ((mA >= 0) ? 1 : 0);
        if (cv[0] || cv[17]) mCnt = 0;
        else if (cv[12])     mCnt = (mCnt + 1) % 16;
        if      (cv[13]) mOut = mA & 32'hFFFF;
        else if (cv[14]) mOut = mQ;
        else if (cv[15]) mOut = mM;
        if (cv[2]) mM = iv;
        mA = nA; mQ = nQ; mQ1 = nQ1;
    endtask

    task automatic compare_all();
        check("outbus", 32'(outbus), 32'(mOut));
        check("q0", 32'(q0), 32'(mQ & 1));
        check("q_1", 32'(q_1), 32'(mQ1));
        check("a_16", 32'(a_16), (mA < 0) ? 32'd1 : 32'd0);
        check("cnt", 32'(cnt), 32'(mCnt));
        check("cmp_cnt_m4", 32'(cmp_cnt_m4), (mCnt == 15) ? 32'd1 : 32'd0);
        check("ovf", 32'(ovf), 32'(mOvf));
        check("err", 32'(err), 32'(mErr));
    endtask

    task automatic step(input logic [18:0] cv, input logic [15:0] iv);
        @(negedge clk);
        c = cv;
        inbus = iv;
        @(posedge clk);
        model_step(cv, 32'(iv));
        #1;
        compare_all();
    endtask

    function automatic logic [18:0] bit_c(input int b);
        logic [18:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    function automatic logic [18:0] gen_c();
        logic [18:0] cv;
        int r, i, j, k;
        int list[9] = '{3, 4, 5, 6, 7, 8, 9, 10, 16};
        cv = '0;
        r = $urandom_range(0, 99);
        if (r < 3) cv[0] = 1'b1;
        else if (r < 15) begin
            i = $urandom_range(3, 8);
            do j = $urandom_range(3, 8); while (j == i);
            cv[i] = 1'b1;
            cv[j] = 1'b1;
        end else if (r < 80) begin
            k = $urandom_range(0, 8);
            cv[list[k]] = 1'b1;
        end
        cv[1]  = ($urandom_range(0, 3) == 0);
        cv[2]  = ($urandom_range(0, 3) == 0);
        cv[12] = ($urandom_range(0, 2) == 0);
        cv[13] = ($urandom_range(0, 3) == 0);
        cv[14] = ($urandom_range(0, 3) == 0);
        cv[15] = ($urandom_range(0, 3) == 0);
        cv[17] = ($urandom_range(0, 7) == 0);
        r = $urandom_range(0, 5);
        if (r == 0)      cv[11] = 1'b1;
        else if (r == 1) cv[18] = 1'b1;
        return cv;
    endfunction

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst_b = 1'b1;

        // Booth 3 x -5
        step(bit_c(2), 16'h0003);
        step(bit_c(1), 16'hFFFB);
        step(bit_c(0), 16'h0000);
        for (int i = 0; i < 16; i++) begin
            check("booth_cmp", 32'(cmp_cnt_m4), (i == 15) ? 32'd1 : 32'd0);
            if ((mQ & 1) == 0 && mQ1 == 1) step(bit_c(4), 16'h0);
            else if ((mQ & 1) == 1 && mQ1 == 0) step(bit_c(5), 16'h0);
            step(bit_c(9) | bit_c(12), 16'h0);
        end
        check("booth_cnt", 32'(cnt), 32'd0);
        step(bit_c(13), 16'h0);
        check("booth_a", 32'(outbus), 32'h0000FFFF);
        step(bit_c(14), 16'h0);
        check("booth_q", 32'(outbus), 32'h0000FFF1);

        // Restoring division 100 / 7
        step(bit_c(1), 16'd100);
        step(bit_c(2), 16'd7);
        step(bit_c(0), 16'h0);
        for (int i = 0; i < 16; i++) begin
            step(bit_c(10), 16'h0);
            step(bit_c(5), 16'h0);
            step(bit_c(16) | bit_c(18), 16'h0);
            step(bit_c(12), 16'h0);
        end
        step(bit_c(13), 16'h0);
        check("div_rem", 32'(outbus), 32'd2);
        step(bit_c(14), 16'h0);
        check("div_quo", 32'(outbus), 32'd14);

        // Signed overflow, sticky until c0
        step(bit_c(0), 16'h0);
        step(bit_c(3), 16'h7FFF);
        step(bit_c(2), 16'h0001);
        step(bit_c(4), 16'h0);
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_a16", 32'(a_16), 32'd0);
        step(bit_c(13), 16'h0);
        check("ovf_a", 32'(outbus), 32'h00008000);
        step(bit_c(7), 16'h0);
        step(bit_c(4), 16'h0);
        check("ovf_sticky", 32'(ovf), 32'd1);
        step(bit_c(0), 16'h0);
        check("ovf_clr", 32'(ovf), 32'd0);

        // Conflicting A writers
        step(bit_c(3), 16'd5);
        step(bit_c(2), 16'd2);
        step(bit_c(4) | bit_c(5), 16'h0);
        check("err_set", 32'(err), 32'd1);
        step(bit_c(13), 16'h0);
        check("err_a", 32'(outbus), 32'd7);
        step(bit_c(0), 16'h0);
        check("err_clr", 32'(err), 32'd0);

        // Counter terminal value, wrap and clear priority
        for (int i = 1; i <= 15; i++) begin
            step(bit_c(12), 16'h0);
            check("cnt_up", 32'(cnt), 32'(i));
        end
        check("cnt_last", 32'(cmp_cnt_m4), 32'd1);
        step(bit_c(12), 16'h0);
        check("cnt_wrap", 32'(cnt), 32'd0);
        step(bit_c(12), 16'h0);
        step(bit_c(12), 16'h0);
        step(bit_c(12) | bit_c(17), 16'h0);
        check("cnt_c17", 32'(cnt), 32'd0);

        // Hold when c is all zero
        step(bit_c(3), 16'h1234);
        for (int i = 0; i < 3; i++) step('0, 16'($urandom));

        // Random control words
        for (int i = 0; i < 400; i++) step(gen_c(), 16'($urandom));

        // Asynchronous reset mid-operation with A = 0x1FFFF
        step(bit_c(3) | bit_c(11), 16'hFFFF);
        step(bit_c(2) | bit_c(12) | bit_c(14), 16'hABCD);
        check("pre_rst_a16", 32'(a_16), 32'd1);
        #3;
        rst_b = 1'b0;
        model_reset();
        #1;
        compare_all();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            c = gen_c() | bit_c(3);
            inbus = 16'($urandom);
            @(posedge clk);
            #1;
            compare_all();
        end
        @(negedge clk);
        c = '0;
        rst_b = 1'b1;
        for (int i = 0; i < 100; i++) step(gen_c(), 16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
